// File: rtl/mod_recombine_pkg.sv
// Shared definitions for the recombine unit: default width and FSM state encodings.
`timescale 1ns/1ps
package mod_recombine_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_recombine_add_shift_step.sv
// One shift-add multiplier iteration: conditionally accumulate, then shift multiplicand and multiplier.
`timescale 1ns/1ps
module mod_recombine_add_shift_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [2*WIDTH-1:0] i_mc,
    input  logic [WIDTH-1:0]   i_mq,
    output logic [2*WIDTH:0]   o_acc_c,
    output logic [2*WIDTH-1:0] o_mc_c,
    output logic [WIDTH-1:0]   o_mq_c
);

    always_comb begin
        o_acc_c = i_mq[0] ? (i_acc + {1'b0, i_mc}) : i_acc;
        o_mc_c  = i_mc << 1;
        o_mq_c  = i_mq >> 1;
    end

endmodule

// File: rtl/mod_recombine.sv
// Rebuilds q*b + r with a fixed-latency, one-bit-per-clock shift-add multiplier.
`timescale 1ns/1ps
module mod_recombine
    import mod_recombine_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned MC_W  = 2 * WIDTH;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mq;
    logic [MC_W-1:0]    r_mc;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_overflow;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;
    logic [MC_W-1:0]    w_mc_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               w_overflow_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [ACC_W-1:0]   w_step_acc;
    logic [MC_W-1:0]    w_step_mc;
    logic [WIDTH-1:0]   w_step_mq;

    mod_recombine_add_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc   (r_acc),
        .i_mc    (r_mc),
        .i_mq    (r_mq),
        .o_acc_c (w_step_acc),
        .o_mc_c  (w_step_mc),
        .o_mq_c  (w_step_mq)
    );

    // State and datapath registers; busy/done are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mq       <= '0;
            r_mc       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mq       <= w_mq_nxt;
            r_mc       <= w_mc_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_result   <= w_result_nxt;
            r_overflow <= w_overflow_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and datapath update; result is captured only on entry to DONE.
    always_comb begin
        w_state_nxt    = r_state;
        w_mq_nxt       = r_mq;
        w_mc_nxt       = r_mc;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_result_nxt   = r_result;
        w_overflow_nxt = r_overflow;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mq_nxt    = q;
                    w_mc_nxt    = {{WIDTH{1'b0}}, b};
                    w_acc_nxt   = {{(WIDTH + 1){1'b0}}, r};
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(WIDTH)) begin
                    w_result_nxt   = r_acc[WIDTH-1:0];
                    w_overflow_nxt = |r_acc[ACC_W-1:WIDTH];
                    w_state_nxt    = ST_DONE;
                end else begin
                    w_acc_nxt = w_step_acc;
                    w_mc_nxt  = w_step_mc;
                    w_mq_nxt  = w_step_mq;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_mod_recombine.sv
// Directed self-checking bench for mod_recombine (WIDTH = 32).
`timescale 1ns/1ps
module tb_mod_recombine;

    localparam int unsigned W       = 32;
    localparam int          TIMEOUT = 200;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  q;
    logic [W-1:0]  b;
    logic [W-1:0]  r;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          overflow;

    int n_checks;
    int n_errors;

    mod_recombine #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .q        (q),
        .b        (b),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one op and follow it to completion; optionally pulse a stray start during RUN.
    task automatic run_op(input string tag, input logic [W-1:0] vq, input logic [W-1:0] vb,
                          input logic [W-1:0] vr, input logic [W-1:0] exp_res,
                          input logic exp_ovf, input int glitch_cyc);
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1; q = vq; b = vb; r = vr;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (n < TIMEOUT && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1'b1;
            if (n == glitch_cyc) begin
                start = 1'b1; q = '1 & W'(9); b = W'(9); r = W'(9);
            end else if (n == glitch_cyc + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_latency"}, 64'(n), 64'(W + 1));
        check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
        check_eq({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        check_eq({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
        check_eq({tag, "_result_hold"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        int ndone;
        int last;
        n_checks = 0;
        n_errors = 0;
        start = 1'b0; q = '0; b = '0; r = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;

        run_op("basic", W'(2), W'(5), W'(4), W'(14), 1'b0, -10);
        run_op("q_zero", W'(0), W'(32'hDEADBEEF), W'(7), W'(7), 1'b0, -10);
        run_op("b_zero", W'(1), W'(0), W'(0), W'(0), 1'b0, -10);
        run_op("ovf_carry", W'(32'h80000000), W'(2), W'(1), W'(1), 1'b1, -10);
        run_op("all_ones", W'(32'hFFFFFFFF), W'(32'hFFFFFFFF), W'(32'hFFFFFFFF),
               W'(0), 1'b1, -10);

        // A start pulsed mid-RUN must not disturb the op in flight (6*7+1 = 43).
        run_op("ignore_start", W'(6), W'(7), W'(1), W'(43), 1'b0, 5);
        run_op("after_ignore", W'(9), W'(9), W'(9), W'(90), 1'b0, -10);

        // Asynchronous reset between edges during RUN cycle 10.
        @(negedge clk);
        start = 1'b1; q = W'(4); b = W'(4); r = W'(4);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #0.5;
        reset = 1'b0;
        #0.2;
        check_eq("async_rst_busy", 64'(busy), 64'd0);
        check_eq("async_rst_result", 64'(result), 64'd0);
        check_eq("async_rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < int'(W) + 5; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("async_rst_no_done", 64'(ndone), 64'd0);
        run_op("post_reset", W'(3), W'(7), W'(2), W'(23), 1'b0, -10);

        // start held high: accepted only from IDLE; DONE->IDLE takes an edge, then IDLE accepts.
        @(negedge clk);
        start = 1'b1; q = W'(1); b = W'(1); r = W'(1);
        ndone = 0;
        last  = -1;
        for (int c = 0; c < 3 * (int'(W) + 3) + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                check_eq("b2b_result", 64'(result), 64'd2);
                if (last >= 0) check_eq("b2b_period", 64'(c - last), 64'(W + 3));
                else           check_eq("b2b_first", 64'(c), 64'(W + 1));
                last = c;
            end
        end
        start = 1'b0;
        check_eq("b2b_count", 64'(ndone), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
